pipe_ctrl_n: RTL and testbench
==============================

// Module: pipe_ctrl_n
// PURPOSE
//  Parametrised N-stage valid/allow_in pipeline skeleton with per-stage payload registers, masked flush, and perf counters.
//  Replaces the hand-written 5-stage valid/bus chain in the CPU top. Datapath stages plug in through st_over/st_bus_nxt.
//  Adds a selective flush mask (the old cancel cleared all stages) and retire/stall/flush counters.
// PARAMETERS
//  STAGES   5   number of pipeline stages, >=2
//  BUS_WD   64  payload width carried into each stage (uniform; unused bits tie 0)
//  CNT_WD   32  width of each performance counter, wraps
// PORTS
//  clk          in   1               clock
//  resetn       in   1               synchronous reset, active low
//  in_valid     in   1               producer (fetch) has a payload for stage 0
//  in_bus       in   BUS_WD          payload into stage 0
//  in_ready     out  1               stage 0 accepts in_bus this cycle
//  st_over      in   STAGES          stage i finished its work this cycle (from datapath)
//  st_bus_nxt   in   STAGES*BUS_WD   payload stage i hands to stage i+1 (slice i); slice STAGES-1 -> out_bus
//  st_valid     out  STAGES          stage i holds a live payload
//  st_bus       out  STAGES*BUS_WD   registered payload of stage i
//  st_fire      out  STAGES          stage i hands off this cycle
//  out_valid    out  1               last stage retiring
//  out_bus      out  BUS_WD          = st_bus_nxt slice STAGES-1
//  out_ready    in   1               sink accepts retirement
//  flush        in   1               kill request
//  flush_mask   in   STAGES          stages cleared by flush (bit i = stage i)
//  cnt_clr      in   1               clear all counters
//  retire_cnt   out  CNT_WD          retired payloads
//  stall_cnt    out  CNT_WD          cycles with in_valid & ~in_ready
//  flush_cnt    out  CNT_WD          cycles with flush asserted
// BEHAVIOUR
//  Reset (posedge clk, resetn=0): st_valid=0, st_bus=0, all counters=0; outputs derived from these.
//  allow_in[i] = ~st_valid[i] | (st_over[i] & allow_in[i+1]); allow_in[STAGES] = out_ready.
//  kill[i] = flush & flush_mask[i].
//  st_fire[i] = st_valid[i] & st_over[i] & allow_in[i+1] & ~kill[i]; out_valid = st_valid[S-1] & st_over[S-1] & ~kill[S-1].
//  in_ready = allow_in[0] | kill[0]  (a payload offered during a stage-0 kill is consumed and dropped).
//  Stage 0 update: kill[0] -> valid<=0; else if allow_in[0] -> valid<=in_valid, bus<=in_bus when in_valid.
//  Stage i>0 update: kill[i] -> valid<=0; else if allow_in[i] -> valid<=st_fire[i-1], bus<=st_bus_nxt[i-1] when st_fire[i-1].
//  Kill dominates advance; a killed stage never passes its payload downstream (st_fire gated).
//  Unmasked stage whose upstream is killed: receives a bubble (valid<=0) if allow_in, else holds.
//  Holding stage (allow_in=0): valid and bus unchanged.
//  Latency: a payload with st_over=1 everywhere and no back-pressure reaches out_valid STAGES cycles after in_valid&in_ready.
//  Throughput: 1 payload/cycle when out_ready=1 and all st_over=1.
//  Counters: +1 per qualifying cycle, wrap at 2^CNT_WD; cnt_clr dominates increment (value 0 next cycle).
//   retire_cnt: out_valid & out_ready. stall_cnt: in_valid & ~in_ready. flush_cnt: flush (mask irrelevant).
//  flush_mask ignored when flush=0; all-zero mask with flush=1 only bumps flush_cnt.
//  Reset mid-operation discards all in-flight payloads; no partial retirement that cycle.
// STRUCTURE
//  Shared constants (`PIPE_STAGES, `PIPE_BUS_WD, stage index names IF/ID/EXE/MEM/WB) go in CPU.vh.
//  One sub-module pipe_stage_reg: single valid+payload slice (inputs allow_in, kill, up_fire, up_bus);
//  instantiated via generate for STAGES slices; allow_in chain and counters stay in pipe_ctrl_n.
//  allow_in chain is combinational back to front; no combinational path from st_bus to in_ready.
// TESTING
//  1 Streaming: STAGES=5, all st_over=1, out_ready=1, in_bus=1..10 back-to-back -> out_bus 1..10 on cycles 5..14, retire_cnt=10, stall_cnt=0.
//  2 Back-pressure: fill pipe, out_ready=0 for 3 cycles -> all st_valid=1, st_bus frozen, in_ready=0, stall_cnt+=3; release -> no loss/dup.
//  3 Mid stall: st_over[2]=0 for 2 cycles -> stages 0-2 hold, stages 3-4 drain to bubbles, order preserved afterwards.
//  4 Full flush: flush=1, mask=5'b11110 with in_valid=1 -> st_valid[4:1]=0 next cycle, stage0 loads in_bus, flush_cnt=1, retire_cnt unchanged.
//  5 Partial flush: mask=5'b00011 with stage1 over -> stage2 gets bubble, stages 3-4 retire normally, in_ready=1 and input dropped.
//  6 Reset/counters: resetn=0 mid-stream -> all st_valid=0, counters 0; CNT_WD=4 retire 17 -> retire_cnt=1; cnt_clr with retire -> 0.

Source files
------------

// File: rtl/pipe_ctrl_n_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_n_pkg
// Shared constants for the valid/allow_in pipeline skeleton.
//   PIPE_STAGES / PIPE_BUS_WD / PIPE_CNT_WD : default geometry of the CPU pipe
//   stage_idx_e                             : symbolic stage indices IF..WB
// No ports; imported by pipe_ctrl_n and pipe_stage_reg.
// ----------------------------------------------------------------------------
package pipe_ctrl_n_pkg;

    localparam int PIPE_STAGES = 5;
    localparam int PIPE_BUS_WD = 64;
    localparam int PIPE_CNT_WD = 32;

    // Stage positions of the classic five-stage CPU, usable as flush_mask
    // bit indices and st_* slice indices.
    typedef enum logic [2:0] {
        STG_IF  = 3'd0,
        STG_ID  = 3'd1,
        STG_EXE = 3'd2,
        STG_MEM = 3'd3,
        STG_WB  = 3'd4
    } stage_idx_e;

endpackage

// File: rtl/pipe_ctrl_n_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline slice: a valid bit plus its payload register.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   allow_in_i   : this slice may take a new entry (empty or draining)
//   kill_i       : flush hit this slice; drop whatever it holds
//   up_fire_i    : upstream hands off a payload this cycle
//   up_bus_i     : payload offered by upstream
//   valid_o      : slice holds a live payload
//   bus_o        : registered payload
// ----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_ctrl_n_pkg::*;
#(
    parameter int BUS_WD = PIPE_BUS_WD
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              allow_in_i,
    input  logic              kill_i,
    input  logic              up_fire_i,
    input  logic [BUS_WD-1:0] up_bus_i,
    output logic              valid_o,
    output logic [BUS_WD-1:0] bus_o
);

    logic              valid_q;
    logic              valid_d;
    logic [BUS_WD-1:0] bus_q;
    logic [BUS_WD-1:0] bus_d;

    // Next-state for the slice. Kill wins over everything; otherwise an open
    // slice takes whatever upstream fires (a bubble if upstream does not fire),
    // and a closed slice holds. The payload only moves when a real entry
    // arrives, so bubbles leave the old bits behind harmlessly.
    always_comb begin
        valid_d = valid_q;
        bus_d   = bus_q;
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (allow_in_i) begin
            valid_d = up_fire_i;
            if (up_fire_i) begin
                bus_d = up_bus_i;
            end
        end
    end

    // Slice registers with synchronous reset to an empty, zeroed slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            bus_q   <= '0;
        end else begin
            valid_q <= valid_d;
            bus_q   <= bus_d;
        end
    end

    assign valid_o = valid_q;
    assign bus_o   = bus_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_n
// Parametrised STAGES-deep valid/allow_in pipeline skeleton with per-stage
// payload registers, a masked flush and retire/stall/flush counters.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   in_valid, in_bus         : producer payload for stage 0
//   in_ready                 : stage 0 consumes in_bus this cycle
//   st_over[i]               : datapath says stage i finished its work
//   st_bus_nxt[slice i]      : payload stage i hands to stage i+1
//   st_valid, st_bus         : per-stage live flag and registered payload
//   st_fire[i]               : stage i hands off this cycle
//   out_valid, out_bus       : last stage retiring, with its outgoing payload
//   out_ready                : sink accepts the retirement
//   flush, flush_mask        : kill request and the stages it clears
//   cnt_clr                  : clear all counters
//   retire_cnt, stall_cnt,
//   flush_cnt                : wrapping performance counters
// ----------------------------------------------------------------------------
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int STAGES = PIPE_STAGES,
    parameter int BUS_WD = PIPE_BUS_WD,
    parameter int CNT_WD = PIPE_CNT_WD
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [BUS_WD-1:0]        in_bus,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        st_over,
    input  logic [STAGES*BUS_WD-1:0] st_bus_nxt,
    output logic [STAGES-1:0]        st_valid,
    output logic [STAGES*BUS_WD-1:0] st_bus,
    output logic [STAGES-1:0]        st_fire,
    output logic                     out_valid,
    output logic [BUS_WD-1:0]        out_bus,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic [STAGES-1:0]        flush_mask,
    input  logic                     cnt_clr,
    output logic [CNT_WD-1:0]        retire_cnt,
    output logic [CNT_WD-1:0]        stall_cnt,
    output logic [CNT_WD-1:0]        flush_cnt
);

    localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

    logic [STAGES:0]          allowIn;
    logic [STAGES-1:0]        kill;
    logic [STAGES-1:0]        upFire;
    logic [STAGES*BUS_WD-1:0] upBus;

    logic [CNT_WD-1:0] retireCnt_q;
    logic [CNT_WD-1:0] retireCnt_d;
    logic [CNT_WD-1:0] stallCnt_q;
    logic [CNT_WD-1:0] stallCnt_d;
    logic [CNT_WD-1:0] flushCnt_q;
    logic [CNT_WD-1:0] flushCnt_d;

    // Back-pressure ripples from the sink toward stage 0: a stage can accept
    // when it is empty, or when it finishes and its successor can accept.
    // The chain only looks at valid/over/out_ready, never at payload bits,
    // so there is no path from st_bus to in_ready.
    always_comb begin
        allowIn         = '0;
        allowIn[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            allowIn[i] = ~st_valid[i] | (st_over[i] & allowIn[i + 1]);
        end
    end

    // The mask only matters while flush is high.
    assign kill = flush ? flush_mask : '0;

    // A killed stage never passes its payload on, even if downstream is open.
    assign st_fire   = st_valid & st_over & allowIn[STAGES:1] & ~kill;
    assign out_valid = st_valid[STAGES-1] & st_over[STAGES-1] & ~kill[STAGES-1];
    assign out_bus   = st_bus_nxt[(STAGES-1)*BUS_WD +: BUS_WD];

    // Offering into a stage-0 kill still handshakes: the payload is consumed
    // and dropped rather than stalling the producer.
    assign in_ready = allowIn[0] | kill[0];

    // Stage 0 is fed by the producer, every later stage by its predecessor.
    assign upFire = {st_fire[STAGES-2:0], in_valid};
    assign upBus  = {st_bus_nxt[(STAGES-1)*BUS_WD-1:0], in_bus};

    // One valid+payload slice per stage.
    for (genvar g = 0; g < STAGES; g++) begin : gStage
        pipe_stage_reg #(
            .BUS_WD (BUS_WD)
        ) uStage (
            .clk        (clk),
            .resetn     (resetn),
            .allow_in_i (allowIn[g]),
            .kill_i     (kill[g]),
            .up_fire_i  (upFire[g]),
            .up_bus_i   (upBus[g*BUS_WD +: BUS_WD]),
            .valid_o    (st_valid[g]),
            .bus_o      (st_bus[g*BUS_WD +: BUS_WD])
        );
    end

    // Counter next-state. A clear beats any increment in the same cycle;
    // otherwise each counter bumps on its qualifying event and wraps freely.
    always_comb begin
        retireCnt_d = retireCnt_q;
        stallCnt_d  = stallCnt_q;
        flushCnt_d  = flushCnt_q;
        if (cnt_clr) begin
            retireCnt_d = '0;
            stallCnt_d  = '0;
            flushCnt_d  = '0;
        end else begin
            if (out_valid & out_ready) begin
                retireCnt_d = retireCnt_q + CNT_ONE;
            end
            if (in_valid & ~in_ready) begin
                stallCnt_d = stallCnt_q + CNT_ONE;
            end
            if (flush) begin
                flushCnt_d = flushCnt_q + CNT_ONE;
            end
        end
    end

    // Counter registers, zeroed by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            retireCnt_q <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            retireCnt_q <= retireCnt_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign retire_cnt = retireCnt_q;
    assign stall_cnt  = stallCnt_q;
    assign flush_cnt  = flushCnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl_n
// Directed bench for pipe_ctrl_n with STAGES=5, 16-bit payloads. A second
// instance with 4-bit counters shares all inputs to exercise counter wrap.
// The stand-in datapath adds 1 at every stage, so a payload entering with
// value v sits as v+k in stage k and leaves as out_bus = v+5.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl_n;

    localparam int S  = 5;
    localparam int W  = 16;
    localparam int C  = 32;
    localparam int CN = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           in_valid;
    logic [W-1:0]   in_bus;
    logic [S-1:0]   st_over;
    logic [S*W-1:0] st_bus_nxt;
    logic           out_ready;
    logic           flush;
    logic [S-1:0]   flush_mask;
    logic           cnt_clr;

    logic           in_ready;
    logic [S-1:0]   st_valid;
    logic [S*W-1:0] st_bus;
    logic [S-1:0]   st_fire;
    logic           out_valid;
    logic [W-1:0]   out_bus;
    logic [C-1:0]   retire_cnt;
    logic [C-1:0]   stall_cnt;
    logic [C-1:0]   flush_cnt;

    logic           nInReady;
    logic [S-1:0]   nStValid;
    logic [S*W-1:0] nStBus;
    logic [S-1:0]   nStFire;
    logic           nOutValid;
    logic [W-1:0]   nOutBus;
    logic [CN-1:0]  nRetireCnt;
    logic [CN-1:0]  nStallCnt;
    logic [CN-1:0]  nFlushCnt;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] t2Exp [6];

    always #5 clk = ~clk;

    // Stand-in datapath: every stage increments the payload it passes on.
    always_comb begin
        st_bus_nxt = '0;
        for (int i = 0; i < S; i++) begin
            st_bus_nxt[i*W +: W] = st_bus[i*W +: W] + 16'd1;
        end
    end

    pipe_ctrl_n #(.STAGES(S), .BUS_WD(W), .CNT_WD(C)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_bus     (in_bus),
        .in_ready   (in_ready),
        .st_over    (st_over),
        .st_bus_nxt (st_bus_nxt),
        .st_valid   (st_valid),
        .st_bus     (st_bus),
        .st_fire    (st_fire),
        .out_valid  (out_valid),
        .out_bus    (out_bus),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_mask (flush_mask),
        .cnt_clr    (cnt_clr),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    pipe_ctrl_n #(.STAGES(S), .BUS_WD(W), .CNT_WD(CN)) dutNarrow (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_bus     (in_bus),
        .in_ready   (nInReady),
        .st_over    (st_over),
        .st_bus_nxt (st_bus_nxt),
        .st_valid   (nStValid),
        .st_bus     (nStBus),
        .st_fire    (nStFire),
        .out_valid  (nOutValid),
        .out_bus    (nOutBus),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_mask (flush_mask),
        .cnt_clr    (cnt_clr),
        .retire_cnt (nRetireCnt),
        .stall_cnt  (nStallCnt),
        .flush_cnt  (nFlushCnt)
    );

    // Drive every DUT input for the coming cycle in one go.
    task automatic applyStimulus(input logic rstn, input logic v, input logic [W-1:0] b,
                                 input logic ordy, input logic [S-1:0] over,
                                 input logic fl, input logic [S-1:0] mask, input logic clr);
        resetn     = rstn;
        in_valid   = v;
        in_bus     = b;
        out_ready  = ordy;
        st_over    = over;
        flush      = fl;
        flush_mask = mask;
        cnt_clr    = clr;
    endtask

    // One comparison point: count it, and count and report it when it misses.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] busOf(input int k);
        return st_bus[k*W +: W];
    endfunction

    initial begin
        t2Exp = '{16'h25, 16'h27, 16'h29, 16'h2B, 16'h2D, 16'h45};

        // Reset state
        applyStimulus(1'b0, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_st_valid", st_valid, 5'b00000);
        checkOutput("rst_st_bus", st_bus, 80'h0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_retire_cnt", retire_cnt, 32'd0);
        checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
        checkOutput("rst_flush_cnt", flush_cnt, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        @(negedge clk);

        // Streaming: 1..10 back-to-back, out_bus = v+5 on cycles 5..14
        $display("[TB] streaming");
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, c < 10, W'(c + 1), 1'b1, '1, 1'b0, '0, 1'b0);
            #1;
            checkOutput("t1_out_valid", out_valid, (c >= 5 && c < 15));
            if (c >= 5 && c < 15) checkOutput("t1_out_bus", out_bus, 128'(c + 1));
            checkOutput("t1_in_ready", in_ready, 1'b1);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t1_retire_cnt", retire_cnt, 32'd10);
        checkOutput("t1_stall_cnt", stall_cnt, 32'd0);
        checkOutput("t1_st_valid", st_valid, 5'b00000);
        @(negedge clk);

        // Back-pressure: fill, hold out_ready low 3 cycles, release
        $display("[TB] back-pressure");
        for (int c = 0; c < 15; c++) begin
            applyStimulus(1'b1, c <= 8, (c < 5) ? W'(32'h20 + 2 * c) : 16'h40,
                          !(c >= 5 && c <= 7), '1, 1'b0, '0, 1'b0);
            #1;
            if (c >= 5 && c <= 7) begin
                checkOutput("t2_hold_st_valid", st_valid, 5'b11111);
                checkOutput("t2_hold_in_ready", in_ready, 1'b0);
                checkOutput("t2_hold_st_bus", st_bus, {16'h24, 16'h25, 16'h26, 16'h27, 16'h28});
                checkOutput("t2_hold_out_bus", out_bus, 16'h25);
            end
            if (c >= 5 && c <= 13) checkOutput("t2_out_valid", out_valid, 1'b1);
            else checkOutput("t2_out_valid", out_valid, 1'b0);
            if (c >= 8 && c <= 13) checkOutput("t2_out_bus", out_bus, t2Exp[c - 8]);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t2_stall_cnt", stall_cnt, 32'd3);
        checkOutput("t2_retire_cnt", retire_cnt, 32'd16);
        @(negedge clk);

        // Mid stall: stage 2 not over for two cycles
        $display("[TB] mid stall");
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, c <= 9,
                          (c < 5) ? W'(32'h50 + c) : ((c < 7) ? 16'h55 : ((c <= 9) ? W'(32'h4E + c) : 16'h0)),
                          1'b1, (c == 5 || c == 6) ? 5'b11011 : 5'b11111, 1'b0, '0, 1'b0);
            #1;
            checkOutput("t3_out_valid", out_valid, (c == 5 || c == 6 || (c >= 9 && c <= 14)));
            if (c == 5) checkOutput("t3_out_bus", out_bus, 16'h55);
            if (c == 6) checkOutput("t3_out_bus", out_bus, 16'h56);
            if (c >= 9 && c <= 14) checkOutput("t3_out_bus", out_bus, 128'(32'h4E + c));
            if (c == 5 || c == 6) checkOutput("t3_in_ready", in_ready, 1'b0);
            if (c == 7) checkOutput("t3_in_ready", in_ready, 1'b1);
            if (c == 6) checkOutput("t3_st_valid", st_valid, 5'b10111);
            if (c == 7) checkOutput("t3_st_valid", st_valid, 5'b00111);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t3_stall_cnt", stall_cnt, 32'd5);
        checkOutput("t3_retire_cnt", retire_cnt, 32'd24);
        checkOutput("t3_st_valid_end", st_valid, 5'b00000);
        @(negedge clk);

        // Full flush of stages 1-4 while stage 0 loads
        $display("[TB] full flush");
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, c <= 5, (c < 5) ? W'(32'h60 + c) : 16'h70,
                          1'b1, '1, c == 5, (c == 5) ? 5'b11110 : 5'b00000, 1'b0);
            #1;
            if (c == 5) begin
                checkOutput("t4_out_valid", out_valid, 1'b0);
                checkOutput("t4_in_ready", in_ready, 1'b1);
                checkOutput("t4_st_fire", st_fire, 5'b00001);
            end
            if (c == 6) begin
                checkOutput("t4_st_valid", st_valid, 5'b00001);
                checkOutput("t4_stage0_bus", busOf(0), 16'h70);
                checkOutput("t4_flush_cnt", flush_cnt, 32'd1);
                checkOutput("t4_retire_hold", retire_cnt, 32'd24);
            end
            if (c == 10) begin
                checkOutput("t4_drain_valid", out_valid, 1'b1);
                checkOutput("t4_drain_bus", out_bus, 16'h75);
            end
            if (c == 11) checkOutput("t4_retire_cnt", retire_cnt, 32'd25);
            @(negedge clk);
        end

        // Partial flush of stages 0-1 with input offered; mask ignored while flush=0
        $display("[TB] partial flush");
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b1, c <= 5, (c < 5) ? W'(32'h80 + c) : 16'h90,
                          1'b1, '1, c == 5, (c == 5) ? 5'b00011 : 5'b11111, 1'b0);
            #1;
            if (c == 5) begin
                checkOutput("t5_out_valid", out_valid, 1'b1);
                checkOutput("t5_out_bus", out_bus, 16'h85);
                checkOutput("t5_in_ready", in_ready, 1'b1);
                checkOutput("t5_st_fire", st_fire, 5'b11100);
            end
            if (c == 6) begin
                checkOutput("t5_st_valid", st_valid, 5'b11000);
                checkOutput("t5_flush_cnt", flush_cnt, 32'd2);
                checkOutput("t5_out_bus1", out_bus, 16'h86);
            end
            if (c == 7) checkOutput("t5_out_bus2", out_bus, 16'h87);
            if (c == 8) begin
                checkOutput("t5_st_valid_end", st_valid, 5'b00000);
                checkOutput("t5_retire_cnt", retire_cnt, 32'd28);
                checkOutput("t5_stall_cnt", stall_cnt, 32'd5);
            end
            @(negedge clk);
        end

        // Flush with an all-zero mask only bumps flush_cnt
        $display("[TB] zero-mask flush");
        for (int c = 0; c < 11; c++) begin
            applyStimulus(1'b1, c < 5, (c < 5) ? W'(32'hA0 + c) : 16'h0,
                          1'b1, '1, c == 5, 5'b00000, 1'b0);
            #1;
            if (c == 5) begin
                checkOutput("t5b_out_bus", out_bus, 16'hA5);
                checkOutput("t5b_st_fire", st_fire, 5'b11111);
            end
            if (c == 6) begin
                checkOutput("t5b_st_valid", st_valid, 5'b11110);
                checkOutput("t5b_flush_cnt", flush_cnt, 32'd3);
            end
            if (c >= 6 && c <= 9) checkOutput("t5b_drain_bus", out_bus, 128'(32'hA0 + c));
            if (c == 10) checkOutput("t5b_retire_cnt", retire_cnt, 32'd33);
            @(negedge clk);
        end

        // Reset mid-stream discards everything
        $display("[TB] reset mid-stream");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c != 3, 1'b1, W'(32'hB0 + c), 1'b1, '1, 1'b0, '0, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1, '1, 1'b0, '0, 1'b0);
        #1;
        checkOutput("t6_rst_st_valid", st_valid, 5'b00000);
        checkOutput("t6_rst_st_bus", st_bus, 80'h0);
        checkOutput("t6_rst_retire", retire_cnt, 32'd0);
        checkOutput("t6_rst_stall", stall_cnt, 32'd0);
        checkOutput("t6_rst_flush", flush_cnt, 32'd0);
        checkOutput("t6_rst_narrow_retire", nRetireCnt, 4'd0);
        @(negedge clk);

        // 17 retirements: wide counter 17, 4-bit counter wraps to 1
        for (int c = 0; c < 23; c++) begin
            applyStimulus(1'b1, c < 17, W'(32'hC0 + c), 1'b1, '1, 1'b0, '0, 1'b0);
            #1;
            if (c == 21) begin
                checkOutput("t6_last_bus", out_bus, 16'hD5);
                checkOutput("t6_wide_16", retire_cnt, 32'd16);
                checkOutput("t6_narrow_wrap0", nRetireCnt, 4'd0);
            end
            if (c == 22) begin
                checkOutput("t6_wide_17", retire_cnt, 32'd17);
                checkOutput("t6_narrow_1", nRetireCnt, 4'd1);
            end
            @(negedge clk);
        end

        // cnt_clr in the same cycle as a retirement and a flush
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, c == 0, 16'hE0, 1'b1, '1, c == 5, 5'b00000, c == 5);
            #1;
            if (c == 5) checkOutput("t6_clr_out_valid", out_valid, 1'b1);
            if (c == 6) begin
                checkOutput("t6_clr_retire", retire_cnt, 32'd0);
                checkOutput("t6_clr_flush", flush_cnt, 32'd0);
                checkOutput("t6_clr_narrow", nRetireCnt, 4'd0);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
